// File: rtl/ysyx_23060184_ifu_pkg.sv
// Shared definitions for the ysyx_23060184 instruction fetch unit:
// FSM encoding, reset PC, NOP encoding and AXI read-response codes.
package ysyx_23060184_ifu_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_RESP  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [1:0]  RRESP_OKAY       = 2'b00;

endpackage

// File: rtl/ysyx_23060184_pc_gen.sv
// Fetch PC register with a pending-redirect slot; on advance the PC moves to
// the newest redirect target if one exists, otherwise to PC+4.
module ysyx_23060184_pc_gen
    import ysyx_23060184_ifu_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_plus4,
    output logic                  pend_v
);

    logic [DATA_WIDTH-1:0] pend_pc;

    assign pc_plus4 = pc + DATA_WIDTH'(4);

    // A redirect arriving in the same cycle as advance is newer than pend_pc.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc      <= RESET_PC;
            pend_v  <= 1'b0;
            pend_pc <= RESET_PC;
        end else if (advance) begin
            pc     <= redirect ? redirect_pc : (pend_v ? pend_pc : pc_plus4);
            pend_v <= 1'b0;
        end else if (redirect) begin
            pend_v  <= 1'b1;
            pend_pc <= redirect_pc;
        end
    end

endmodule

// File: rtl/ysyx_23060184_ifu.sv
// Instruction fetch unit: one outstanding AXI4-Lite read, IF/ID handshake.
// Optional access-fault handling is enabled by YSYX_23060184_IFU_FAULT_EN.
module ysyx_23060184_ifu
    import ysyx_23060184_ifu_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  Redirect,
    input  logic [DATA_WIDTH-1:0] RedirectPC,
    output logic                  Ivalid,
    input  logic                  Dready,
    output logic [DATA_WIDTH-1:0] InstF,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic [DATA_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic                  InstFault
);

    ifu_state_e            state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  pend_v;
    logic                  advance;
    logic                  redirect_ok;
    logic                  fault_hit;
    logic                  r_hs;
    logic                  fault_q;

`ifdef YSYX_23060184_IFU_FAULT_EN
    assign fault_hit = (rresp != RRESP_OKAY);
`else
    logic unused_rresp;
    assign unused_rresp = ^rresp;
    assign fault_hit    = 1'b0;
`endif

    assign redirect_ok = Redirect && (state != S_FAULT);
    assign r_hs        = rvalid && rready;
    assign araddr      = pc;
    assign InstFault   = fault_q;

    // The PC only moves when a fetch is retired: discarded in S_RESP or leaving S_HOLD.
    always_comb begin
        advance = 1'b0;
        case (state)
            S_RESP:  advance = r_hs && !fault_hit && (redirect_ok || pend_v);
            S_HOLD:  advance = redirect_ok || Dready;
            default: advance = 1'b0;
        endcase
    end

    ysyx_23060184_pc_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_gen (
        .clk         (clk),
        .rstn        (rstn),
        .redirect    (redirect_ok),
        .redirect_pc (RedirectPC),
        .advance     (advance),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .pend_v      (pend_v)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_REQ;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            Ivalid   <= 1'b0;
            fault_q  <= 1'b0;
            InstF    <= DATA_WIDTH'(INST_NOP);
            PCF      <= RESET_PC;
            PCPlus4F <= RESET_PC + DATA_WIDTH'(4);
        end else begin
            case (state)
                S_REQ: begin
                    if (arvalid && arready) begin
                        state   <= S_RESP;
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end else begin
                        arvalid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (r_hs) begin
                        rready <= 1'b0;
                        if (fault_hit) begin
                            state   <= S_FAULT;
                            fault_q <= 1'b1;
                        end else if (redirect_ok || pend_v) begin
                            state   <= S_REQ;
                            arvalid <= 1'b1;
                        end else begin
                            state    <= S_HOLD;
                            Ivalid   <= 1'b1;
                            InstF    <= rdata;
                            PCF      <= pc;
                            PCPlus4F <= pc_plus4;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect_ok || Dready) begin
                        state   <= S_REQ;
                        Ivalid  <= 1'b0;
                        arvalid <= 1'b1;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule
